// File: rtl/bist_pkg.sv
// Shared types and tables for the March C- BIST pattern generator.
// Element tables are indexed by element number; bits 6..7 are unused padding.
package bist_pkg;

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   localparam logic [2:0] M0 = 3'd0;
   localparam logic [2:0] M1 = 3'd1;
   localparam logic [2:0] M2 = 3'd2;
   localparam logic [2:0] M3 = 3'd3;
   localparam logic [2:0] M4 = 3'd4;
   localparam logic [2:0] M5 = 3'd5;

   // Per-element bit tables: direction, read present, read background, write present, write background
   localparam logic [7:0] EL_DOWN   = 8'b0001_1000;
   localparam logic [7:0] EL_HAS_RD = 8'b0011_1110;
   localparam logic [7:0] EL_RD_BG  = 8'b0001_0100;
   localparam logic [7:0] EL_HAS_WR = 8'b0001_1111;
   localparam logic [7:0] EL_WR_BG  = 8'b0000_1010;

   localparam logic [7:0] BG0 = 8'h00;
   localparam logic [7:0] BG1 = 8'hFF;
   localparam logic [7:0] CHK = 8'h55;

endpackage

// File: rtl/bist_march_gen_if.sv
// Memory/comparator-facing bus of the March C- generator.
interface bist_march_gen_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              START;
   logic              BIST_EN;
   logic [2:0]        BIST_MODE;
   logic              EN;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] WDATA;
   logic [DATA_W-1:0] ANSWER;
   logic              BUSY;
   logic              DONE;

   modport master (
      input  START,
      output BIST_EN, BIST_MODE, EN, ADDR, WDATA, ANSWER, BUSY, DONE
   );

   modport slave (
      output START,
      input  BIST_EN, BIST_MODE, EN, ADDR, WDATA, ANSWER, BUSY, DONE
   );
endinterface

// File: rtl/bist_addr_cnt.sv
// Up/down address counter with clear, element-start load, step and terminal flag.
// The terminal compare is made before stepping, so the count never wraps.
module bist_addr_cnt #(
   parameter int ADDR_W    = 8,
   parameter int LAST_ADDR = 2**ADDR_W-1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic              load_down,
   input  logic              step,
   input  logic              down,
   output logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] addr_nxt,
   output logic              term
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

   assign term = down ? (addr == '0) : (addr == LAST);

   always_comb begin
      addr_nxt = addr;
      if (clr)
         addr_nxt = '0;
      else if (load)
         addr_nxt = load_down ? LAST : '0;
      else if (step)
         addr_nxt = down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         addr <= '0;
      else
         addr <= addr_nxt;
   end

endmodule

// File: rtl/bist_march_gen.sv
// March C- pattern generator driving memory and BIST comparator each rising CE.
// Define BIST_CHKBD_EN for address-checkerboard backgrounds (0x55/0xAA) instead of 0x00/0xFF.
module bist_march_gen
   import bist_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int LAST_ADDR = 2**ADDR_W-1
) (
   input  logic              CE,
   input  logic              rst,
   bist_march_gen_if.master  bus
);

`ifdef BIST_CHKBD_EN
   localparam logic [DATA_W-1:0] BASE     = DATA_W'(CHK);
   localparam logic [DATA_W-1:0] PAR_MASK = '1;
`else
   localparam logic [DATA_W-1:0] BASE     = DATA_W'(BG0);
   localparam logic [DATA_W-1:0] PAR_MASK = '0;
`endif

   state_t            state, nxt_state;
   logic [2:0]        mode, nxt_mode;
   logic              last_op;
   logic              cnt_clr, cnt_load, cnt_load_down, cnt_step, cnt_term;
   logic [ADDR_W-1:0] addr, addr_nxt;

   // Background B0 (one=0) or B1 (one=1) for the given address parity
   function automatic logic [DATA_W-1:0] bg(input logic one, input logic a0);
      logic [DATA_W-1:0] b0;
      b0 = BASE ^ ({DATA_W{a0}} & PAR_MASK);
      return one ? ~b0 : b0;
   endfunction

   bist_addr_cnt #(
      .ADDR_W    (ADDR_W),
      .LAST_ADDR (LAST_ADDR)
   ) u_addr_cnt (
      .clk       (CE),
      .rst       (rst),
      .clr       (cnt_clr),
      .load      (cnt_load),
      .load_down (cnt_load_down),
      .step      (cnt_step),
      .down      (EL_DOWN[mode]),
      .addr      (addr),
      .addr_nxt  (addr_nxt),
      .term      (cnt_term)
   );

   assign last_op = (state == WR) || !EL_HAS_WR[mode];

   always_comb begin
      nxt_state     = state;
      nxt_mode      = mode;
      cnt_clr       = 1'b0;
      cnt_load      = 1'b0;
      cnt_load_down = 1'b0;
      cnt_step      = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (bus.START) begin
               nxt_mode      = M0;
               cnt_load      = 1'b1;
               cnt_load_down = EL_DOWN[M0];
               nxt_state     = EL_HAS_RD[M0] ? RD : WR;
            end
         end
         default: begin
            if (!last_op) begin
               nxt_state = WR;
            end else if (!cnt_term) begin
               cnt_step  = 1'b1;
               nxt_state = EL_HAS_RD[mode] ? RD : WR;
            end else if (mode == M5) begin
               nxt_state = DONE;
               cnt_clr   = 1'b1;
            end else begin
               nxt_mode      = mode + 3'd1;
               cnt_load      = 1'b1;
               cnt_load_down = EL_DOWN[nxt_mode];
               nxt_state     = EL_HAS_RD[nxt_mode] ? RD : WR;
            end
         end
      endcase
   end

   // Outputs are registered from the next state so they align with ADDR
   always_ff @(posedge CE or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mode       <= M0;
         bus.BIST_EN <= 1'b0;
         bus.BUSY   <= 1'b0;
         bus.DONE   <= 1'b0;
         bus.EN     <= 1'b1;
         bus.WDATA  <= '0;
         bus.ANSWER <= '0;
      end else begin
         state      <= nxt_state;
         mode       <= nxt_mode;
         bus.BIST_EN <= (nxt_state == RD) || (nxt_state == WR);
         bus.BUSY   <= (nxt_state == RD) || (nxt_state == WR);
         bus.DONE   <= (nxt_state == DONE);
         bus.EN     <= (nxt_state != RD);
         bus.WDATA  <= (nxt_state == WR) ? bg(EL_WR_BG[nxt_mode], addr_nxt[0]) : '0;
         bus.ANSWER <= (nxt_state == RD) ? bg(EL_RD_BG[nxt_mode], addr_nxt[0]) : '0;
      end
   end

   assign bus.BIST_MODE = mode;
   assign bus.ADDR      = addr;

endmodule

// File: tb/tb_bist_march_gen.sv
// Self-checking bench for bist_march_gen with LAST_ADDR=3 (40 active cycles per run).
// The expected trace is generated from the March C- element list; a negedge process compares it.
module tb_bist_march_gen;

   localparam int LAST = 3;
   localparam int N    = LAST + 1;

   typedef struct packed {
      logic       bist_en;
      logic       busy;
      logic       done;
      logic [2:0] mode;
      logic       en;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] answer;
   } obs_t;

   logic CE  = 1'b0;
   logic rst = 1'b1;

   int   checks = 0;
   int   errors = 0;
   bit   track  = 1'b0;
   obs_t exp_q[$];

   bist_march_gen_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   bist_march_gen #(
      .ADDR_W    (8),
      .DATA_W    (8),
      .LAST_ADDR (LAST)
   ) dut (
      .CE  (CE),
      .rst (rst),
      .bus (bus)
   );

   always #5 CE = ~CE;

   function automatic obs_t sample();
      obs_t o;
      o.bist_en = bus.BIST_EN;
      o.busy    = bus.BUSY;
      o.done    = bus.DONE;
      o.mode    = bus.BIST_MODE;
      o.en      = bus.EN;
      o.addr    = bus.ADDR;
      o.wdata   = bus.WDATA;
      o.answer  = bus.ANSWER;
      return o;
   endfunction

   function automatic obs_t mk(bit be, bit bs, bit dn, int m, bit en, int a, logic [7:0] w, logic [7:0] r);
      obs_t o;
      o.bist_en = be; o.busy = bs; o.done = dn; o.mode = 3'(m);
      o.en = en; o.addr = 8'(a); o.wdata = w; o.answer = r;
      return o;
   endfunction

   // Background value: one=0 -> B0, one=1 -> B1
   function automatic logic [7:0] bgv(int one, int a);
      logic [7:0] b0;
`ifdef BIST_CHKBD_EN
      b0 = (a % 2 == 0) ? 8'h55 : 8'hAA;
`else
      b0 = 8'h00;
`endif
      return (one != 0) ? ~b0 : b0;
   endfunction

   task automatic check_obs(string name, obs_t got, obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got bist_en=%b busy=%b done=%b mode=%0d en=%b addr=%0d wdata=%h answer=%h, expected bist_en=%b busy=%b done=%b mode=%0d en=%b addr=%0d wdata=%h answer=%h",
                  name, got.bist_en, got.busy, got.done, got.mode, got.en, got.addr, got.wdata, got.answer,
                  exp.bist_en, exp.busy, exp.done, exp.mode, exp.en, exp.addr, exp.wdata, exp.answer);
      end
   endtask

   task automatic check_int(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // One full March C- run: {direction down, read bg (-1 none), write bg (-1 none)}
   task automatic push_run();
      bit dn[6] = '{0, 0, 0, 1, 1, 0};
      int rd[6] = '{-1, 0, 1, 0, 1, 0};
      int wr[6] = '{0, 1, 0, 1, 0, -1};
      for (int m = 0; m < 6; m++) begin
         for (int i = 0; i < N; i++) begin
            int a;
            a = dn[m] ? (N - 1 - i) : i;
            if (rd[m] >= 0) exp_q.push_back(mk(1, 1, 0, m, 0, a, 8'h00, bgv(rd[m], a)));
            if (wr[m] >= 0) exp_q.push_back(mk(1, 1, 0, m, 1, a, bgv(wr[m], a), 8'h00));
         end
      end
   endtask

   task automatic push_done(int cycles);
      for (int i = 0; i < cycles; i++) exp_q.push_back(mk(0, 0, 1, 5, 1, 0, 8'h00, 8'h00));
   endtask

   task automatic drain(string name, int budget);
      for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
         @(negedge CE);
         #1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d expected cycles left after %0d cycle budget", name, exp_q.size(), budget);
         exp_q.delete();
      end
      track = 1'b0;
   endtask

   task automatic start_pulse(bit hold);
      @(negedge CE);
      bus.START = 1'b1;
      @(posedge CE);
      #1;
      if (!hold) bus.START = 1'b0;
      track = 1'b1;
   endtask

   // Compare process: one expected entry per cycle while tracking
   always @(negedge CE) begin
      if (track && exp_q.size() > 0) begin
         obs_t e;
         e = exp_q.pop_front();
         check_obs("trace", sample(), e);
      end
   end

   initial begin
      int m3_addr[8]   = '{3, 3, 2, 2, 1, 1, 0, 0};
      logic [7:0] m0_w[4];
      obs_t rst_obs;
      rst_obs = mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
`ifdef BIST_CHKBD_EN
      m0_w = '{8'h55, 8'hAA, 8'h55, 8'hAA};
`else
      m0_w = '{8'h00, 8'h00, 8'h00, 8'h00};
`endif
      bus.START = 1'b0;

      @(negedge CE);
      check_obs("reset_values", sample(), rst_obs);
      rst = 1'b0;

      // Pin the model against hand-derived values
      push_run();
      check_int("model_active_cycles", exp_q.size(), 10 * N);
      for (int i = 0; i < 8; i++) begin
         check_int($sformatf("model_m3_addr%0d", i), int'(exp_q[20 + i].addr), m3_addr[i]);
         check_int($sformatf("model_m3_en%0d", i), int'(exp_q[20 + i].en), i % 2);
      end
`ifndef BIST_CHKBD_EN
      check_int("model_m3_rd_answer", int'(exp_q[20].answer), 'h00);
      check_int("model_m3_wr_wdata", int'(exp_q[21].wdata), 'hFF);
`endif
      for (int a = 0; a < 4; a++) begin
         check_int($sformatf("model_m0_wdata%0d", a), int'(exp_q[a].wdata), int'(m0_w[a]));
         check_int($sformatf("model_m1_answer%0d", a), int'(exp_q[4 + 2 * a].answer), int'(m0_w[a]));
      end

      // Full run from IDLE, DONE persists while START is low
      push_done(3);
      start_pulse(1'b0);
      drain("run_from_idle", 200);

      // Restart from DONE, then asynchronous reset during M2 at ADDR=1 (read)
      push_run();
      start_pulse(1'b0);
      repeat (15) @(negedge CE);
      #2;
      check_int("pre_reset_mode", int'(bus.BIST_MODE), 2);
      check_int("pre_reset_addr", int'(bus.ADDR), 1);
      track = 1'b0;
      exp_q.delete();
      rst = 1'b1;
      #1;
      check_obs("async_reset_mid_run", sample(), rst_obs);
      @(negedge CE);
      check_obs("held_reset", sample(), rst_obs);
      #1 rst = 1'b0;

      // Restart after reset begins at M0, ADDR=0
      push_run();
      push_done(2);
      start_pulse(1'b0);
      drain("run_after_reset", 200);

      // START held high: ignored while busy, new run the cycle after DONE
      push_run();
      push_done(1);
      push_run();
      push_done(2);
      start_pulse(1'b1);
      repeat (50) @(negedge CE);
      #1 bus.START = 1'b0;
      drain("start_held", 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bist_march_gen.md
Name: bist_march_gen

Overview:
- March C- pattern generator for the memory-controller BIST path.
- Drives address, write data, write/read strobe and expected data into the memory and the 8-bit BIST comparator.
- Sequences BIST_MODE per march element so the comparator's sticky fail flag is scoped to each element.
- Updates on rising CE; the comparator samples on falling CE of the same cycle.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- LAST_ADDR, 2**ADDR_W-1, highest tested address (depth-1).

Ports:
- CE  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- START  input  1  level sampled on rising CE; starts a run from IDLE or DONE.
- BIST_EN  output  1  high while a march element is executing.
- BIST_MODE  output  3  current element index 0..5.
- EN  output  1  1 = write cycle, 0 = read/compare cycle.
- ADDR  output  ADDR_W  memory address.
- WDATA  output  DATA_W  write data, valid when EN=1.
- ANSWER  output  DATA_W  expected read data, valid when EN=0 and BIST_EN=1.
- BUSY  output  1  high from the first element cycle through the last.
- DONE  output  1  high in DONE state.

Behaviour:
- Reset (asynchronous, rst=1): state IDLE.
  - BIST_EN=0, BIST_MODE=0, EN=1, ADDR=0, WDATA=0, ANSWER=0, BUSY=0, DONE=0.
- States: IDLE, RD, WR, DONE.
- Backgrounds: B0=8'h00, B1=8'hFF.
- Elements:
  - M0 up: w B0.
  - M1 up: r B0, w B1.
  - M2 up: r B1, w B0.
  - M3 down: r B0, w B1.
  - M4 down: r B1, w B0.
  - M5 up: r B0.
- Up elements start at ADDR=0; down elements start at LAST_ADDR.
- Start: START=1 in IDLE or DONE at a rising edge.
  - Next cycle: BIST_MODE=0, state WR, ADDR=0, EN=1, WDATA=B0, BUSY=1, DONE=0.
  - Latency is 1 cycle.
- Cycle rules:
  - RD cycle: EN=0, ANSWER=expected background, WDATA=0.
  - WR cycle: EN=1, ANSWER=0.
  - Two-op elements alternate RD then WR at the same ADDR.
  - The address steps only after the WR, or after the RD in M5.
- Element end: the address reaches its terminal value (LAST_ADDR for up, 0 for down) and the last op of that address completes.
  - The next cycle starts element k+1 with BIST_MODE=k+1 and a fresh start address.
  - No idle cycle between elements.
- Total active cycles = 10*(LAST_ADDR+1); 2560 at defaults.
- After the final M5 read, the next cycle is DONE:
  - BIST_EN=0, BUSY=0, DONE=1, EN=1.
  - BIST_MODE holds 5 so the comparator keeps its M5 result.
  - ADDR, WDATA and ANSWER return to 0.
- DONE persists until START=1, which restarts exactly as from IDLE.
- START while BUSY: ignored.
- Counters never wrap: the terminal compare precedes increment/decrement, so ADDR stays within [0, LAST_ADDR].
- Reset mid-run: immediate return to reset values; no partial element completes.
- The memory read path is zero-latency; ODATA is valid before the falling CE of the RD cycle.

Optional Feature:
- Macro: BIST_CHKBD_EN.
- Defined: backgrounds become B0 = 8'h55 ^ {8{ADDR[0]}} and B1 = ~B0 (address checkerboard).
  - Applied to WDATA and ANSWER identically.
  - Sequence and timing are unchanged.
- Undefined: solid 8'h00/8'hFF backgrounds.

Decomposition:
- Package bist_pkg holds:
  - State enum (IDLE, RD, WR, DONE).
  - Element index constants M0..M5 and the element direction table (up/down).
  - Per-element op table (has_read, read background, has_write, write background).
  - Background constants BG0=8'h00, BG1=8'hFF, CHK=8'h55.
- Sub-module bist_addr_cnt:
  - ADDR_W up/down counter with load-start, step and terminal flag, parameterized by LAST_ADDR.

Test Plan:
- Reset then START=1 one cycle, LAST_ADDR=3 -> BIST_EN up 1 cycle later, 40 active cycles, then DONE=1, BIST_MODE=5, BUSY=0.
- LAST_ADDR=3, M3 trace -> ADDR sequence 3,3,2,2,1,1,0,0 with EN 0,1,0,1,0,1,0,1, ANSWER=8'h00 on reads, WDATA=8'hFF on writes.
- Connect to comparator with a memory model whose cell 2 is stuck-at-0 bit 7 -> comparator BIST_PASS=1 during M2 and M4, returns to 0 at each mode change.
- Assert rst during M2 at ADDR=1 -> all outputs immediately at reset values; a following START restarts at M0, ADDR=0.
- START held high throughout the run -> no restart while BUSY; a new run starts the cycle after DONE.
- BIST_CHKBD_EN defined, M0 -> WDATA 8'h55, 8'hAA, 8'h55, 8'hAA for ADDR 0..3; M1 reads expect the same values.
